// File: rtl/bm_pkg.sv
`timescale 1ns/1ps
// bm_pkg: types shared by the block-matching scheduler and the minimum-distance stage.
package bm_pkg;

  // Block index carried with every command and every result
  typedef logic [15:0] blk_idx_t;

  // Search offset, vertical in the upper byte, horizontal in the lower byte
  typedef struct packed {
    logic [7:0] v;
    logic [7:0] h;
  } coord_t;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Number of candidate offsets searched for one reference block
  function automatic int offsets_per_blk(input int h_max, input int v_max);
    return (h_max + 1) * (v_max + 1);
  endfunction

endpackage

// File: rtl/match_search_scheduler_scan_counter.sv
`timescale 1ns/1ps
// scan_counter: nested v (inner) / h (outer) / block counters for the offset scan.
// The first/last/frame_last flags are registered alongside the counters so that
// they describe the offset currently presented, without any decode after the flops.
module scan_counter
  import bm_pkg::*;
#(
  parameter int h_max  = 48,
  parameter int v_max  = 8,
  parameter int n_blks = 300
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     clear,
  input  logic     advance,
  output coord_t   coords,
  output blk_idx_t blk,
  output logic     first,
  output logic     last,
  output logic     frame_last
);

  localparam logic [7:0] H_LIM    = 8'(h_max);
  localparam logic [7:0] V_LIM    = 8'(v_max);
  localparam blk_idx_t   LAST_BLK = 16'(n_blks - 1);
  localparam logic       SINGLE_OFFSET = (h_max == 0) && (v_max == 0);

  coord_t   coords_nxt;
  blk_idx_t blk_nxt;
  logic     first_nxt;
  logic     last_nxt;
  logic     frame_last_nxt;

  // Next offset: v steps first, wrapping into h, and h wraps into the block index
  always_comb begin
    coords_nxt = coords;
    blk_nxt    = blk;
    if (clear) begin
      coords_nxt = '0;
      blk_nxt    = '0;
    end else if (advance) begin
      if (coords.v == V_LIM) begin
        coords_nxt.v = '0;
        if (coords.h == H_LIM) begin
          coords_nxt.h = '0;
          blk_nxt      = blk + 16'd1;
        end else begin
          coords_nxt.h = coords.h + 8'd1;
        end
      end else begin
        coords_nxt.v = coords.v + 8'd1;
      end
    end
    first_nxt      = (coords_nxt.h == '0) && (coords_nxt.v == '0);
    last_nxt       = (coords_nxt.h == H_LIM) && (coords_nxt.v == V_LIM);
    frame_last_nxt = last_nxt && (blk_nxt == LAST_BLK);
  end

  // Counter and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coords     <= '0;
      blk        <= '0;
      first      <= 1'b1;
      last       <= SINGLE_OFFSET;
      frame_last <= SINGLE_OFFSET && (n_blks == 1);
    end else begin
      coords     <= coords_nxt;
      blk        <= blk_nxt;
      first      <= first_nxt;
      last       <= last_nxt;
      frame_last <= frame_last_nxt;
    end
  end

endmodule

// File: rtl/match_search_scheduler.sv
`timescale 1ns/1ps
// match_search_scheduler: walks every search offset of every reference block of a
// frame, limits the number of blocks awaiting a minimum-distance result and checks
// that results come back in block order.
module match_search_scheduler
  import bm_pkg::*;
#(
  parameter int blk_w           = 16,
  parameter int blk_h           = 16,
  parameter int search_blk_w    = 64,
  parameter int search_blk_h    = 24,
  parameter int n_blks          = 300,
  parameter int max_outstanding = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_coords,
  output logic [15:0] cmd_blk_index,
  output logic        cmd_last,
  input  logic        res_valid,
  input  logic [15:0] res_blk_index,
  output logic        err
);

  localparam int         H_MAX        = search_blk_w - blk_w;
  localparam int         V_MAX        = search_blk_h - blk_h;
  localparam int         N_OFFSETS    = offsets_per_blk(H_MAX, V_MAX);
  localparam logic [3:0] CREDIT_LIMIT = 4'(max_outstanding);

  // Offsets must fit the 8-bit coordinate fields of the command
  if (H_MAX < 0 || H_MAX > 255 || V_MAX < 0 || V_MAX > 255 || N_OFFSETS < 1) begin : g_bad_window
    $error("match_search_scheduler: search window minus block must be 0..255 in each axis");
  end
  if (n_blks < 1 || n_blks > 65535) begin : g_bad_blocks
    $error("match_search_scheduler: n_blks must be 1..65535");
  end
  if (max_outstanding < 1 || max_outstanding > 15) begin : g_bad_credit
    $error("match_search_scheduler: max_outstanding must be 1..15");
  end

  state_t     state;
  logic [3:0] outstanding;
  logic [3:0] outstanding_nxt;
  blk_idx_t   exp_idx;

  coord_t     scan_coords;
  blk_idx_t   scan_blk;
  logic       scan_first;
  logic       scan_last;
  logic       scan_frame_last;

  logic       handshake;
  logic       start_accept;
  logic       first_issue;
  logic       first_nxt;
  logic       credit_ok;

  scan_counter #(
    .h_max  (H_MAX),
    .v_max  (V_MAX),
    .n_blks (n_blks)
  ) u_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_accept),
    .advance    (handshake),
    .coords     (scan_coords),
    .blk        (scan_blk),
    .first      (scan_first),
    .last       (scan_last),
    .frame_last (scan_frame_last)
  );

  assign cmd_coords    = scan_coords;
  assign cmd_blk_index = scan_blk;
  assign cmd_last      = scan_last;

  // Next outstanding count and whether the offset presented next cycle has credit
  always_comb begin
    handshake       = cmd_valid && cmd_ready;
    start_accept    = (state == IDLE) && start;
    first_issue     = handshake && scan_first;
    outstanding_nxt = outstanding;
    if (start_accept) begin
      outstanding_nxt = '0;
    end else if (first_issue && !res_valid) begin
      outstanding_nxt = outstanding + 4'd1;
    end else if (!first_issue && res_valid && (outstanding != '0)) begin
      outstanding_nxt = outstanding - 4'd1;
    end
    first_nxt = handshake ? scan_last : scan_first;
    credit_ok = !(first_nxt && (outstanding_nxt >= CREDIT_LIMIT));
  end

  // Frame FSM with registered busy/valid/done and the sticky result-order check
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      outstanding <= '0;
      exp_idx     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      cmd_valid   <= 1'b0;
      err         <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      frame_done  <= 1'b0;
      if (res_valid) begin
        if ((outstanding == '0) || (res_blk_index != exp_idx)) begin
          err <= 1'b1;
        end
        exp_idx <= exp_idx + 16'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            err       <= 1'b0;
            exp_idx   <= '0;
          end
        end
        ISSUE: begin
          if (handshake && scan_frame_last) begin
            state     <= DRAIN;
            cmd_valid <= 1'b0;
          end else begin
            cmd_valid <= credit_ok;
          end
        end
        DRAIN: begin
          if (frame_done) begin
            state <= IDLE;
          end else if (outstanding_nxt == '0) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_search_scheduler.sv
`timescale 1ns/1ps
// tb_match_search_scheduler: randomized bench with a frame-level reference model.
module tb_match_search_scheduler;

  localparam int BLK_W       = 16;
  localparam int BLK_H       = 16;
  localparam int SRCH_W      = 20;
  localparam int SRCH_H      = 18;
  localparam int N_BLKS      = 12;
  localparam int MAX_OUT     = 2;
  localparam int H_MAX       = SRCH_W - BLK_W;
  localparam int V_MAX       = SRCH_H - BLK_H;
  localparam int PER_BLK     = (H_MAX + 1) * (V_MAX + 1);
  localparam int TOTAL       = PER_BLK * N_BLKS;
  localparam int FRAME_LIMIT = 4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_coords;
  logic [15:0] cmd_blk_index;
  logic        cmd_last;
  logic        res_valid;
  logic [15:0] res_blk_index;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: position in the frame's flat command list, blocks
  // awaiting results, next result index expected and the expected error flag
  int  cmdIdx;
  int  inflight;
  int  resExpIdx;
  int  stallSeen;
  int  cycleNum;
  int  framesDone;
  bit  running;
  bit  expErr;
  int  resBlkQ[$];
  int  resDueQ[$];

  always #5 clk = ~clk;

  match_search_scheduler #(
    .blk_w           (BLK_W),
    .blk_h           (BLK_H),
    .search_blk_w    (SRCH_W),
    .search_blk_h    (SRCH_H),
    .n_blks          (N_BLKS),
    .max_outstanding (MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .busy          (busy),
    .frame_done    (frame_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_coords    (cmd_coords),
    .cmd_blk_index (cmd_blk_index),
    .cmd_last      (cmd_last),
    .res_valid     (res_valid),
    .res_blk_index (res_blk_index),
    .err           (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    vectors++;
    if (got !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  // One cycle at the falling edge: compare outputs against the model, then pick
  // the inputs for the next rising edge and advance the model accordingly
  task automatic applyStimulus(input int readyPct, input int resDelay, input bit jitter,
                               input bit swapFirst, input bit startNoise);
    int          off;
    int          blk;
    int          rep;
    bit          expValid;
    bit          expDone;
    bit          expBusy;
    bit          hs;
    bit          inc;
    bit          dec;
    logic [31:0] expCoords;
    off      = cmdIdx % PER_BLK;
    expValid = running && (cmdIdx < TOTAL) && !((off == 0) && (inflight >= MAX_OUT));
    expDone  = running && (cmdIdx == TOTAL) && (inflight == 0);
    expBusy  = running && !expDone;
    if (running && (cmdIdx < TOTAL) && !expValid) stallSeen++;
    checkOutput("cmd_valid", cmd_valid, expValid);
    checkOutput("busy", busy, expBusy);
    checkOutput("frame_done", frame_done, expDone);
    checkOutput("err", err, expErr);
    if (expValid) begin
      expCoords = ((off % (V_MAX + 1)) << 8) | (off / (V_MAX + 1));
      checkOutput("cmd_coords", cmd_coords, expCoords);
      checkOutput("cmd_blk_index", cmd_blk_index, cmdIdx / PER_BLK);
      checkOutput("cmd_last", cmd_last, off == PER_BLK - 1);
    end
    if (expDone) begin
      running = 1'b0;
      framesDone++;
    end

    start = expDone && startNoise;
    if (running && startNoise && ($urandom_range(19) == 0)) start = 1'b1;
    cmd_ready     = ($urandom_range(99) < readyPct);
    hs            = expValid && cmd_ready;
    res_valid     = 1'b0;
    res_blk_index = 16'($urandom);
    dec           = 1'b0;
    if ((resDueQ.size() > 0) && (resDueQ[0] <= cycleNum)) begin
      res_valid     = 1'b1;
      res_blk_index = 16'(resBlkQ[0]);
      if ((inflight == 0) || (resBlkQ[0] != resExpIdx)) expErr = 1'b1;
      resExpIdx++;
      void'(resBlkQ.pop_front());
      void'(resDueQ.pop_front());
      dec = 1'b1;
    end
    inc = hs && (off == 0);
    if (inc && !dec) inflight++;
    else if (!inc && dec && (inflight > 0)) inflight--;
    if (hs) begin
      if (off == PER_BLK - 1) begin
        blk = cmdIdx / PER_BLK;
        rep = (swapFirst && (blk < 2)) ? (1 - blk) : blk;
        resBlkQ.push_back(rep);
        resDueQ.push_back(cycleNum + resDelay + (jitter ? int'($urandom_range(3)) : 0));
      end
      cmdIdx++;
    end
    cycleNum++;
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once
  task automatic applyReset();
    reset_n   = 1'b0;
    start     = 1'b0;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    #1;
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_cmd_coords", cmd_coords, 0);
    checkOutput("rst_cmd_blk_index", cmd_blk_index, 0);
    checkOutput("rst_cmd_last", cmd_last, 0);
    checkOutput("rst_err", err, 0);
    running   = 1'b0;
    cmdIdx    = 0;
    inflight  = 0;
    resExpIdx = 0;
    expErr    = 1'b0;
    resBlkQ.delete();
    resDueQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Start a frame and run it to frame_done (or until abortAt commands were issued)
  task automatic runFrame(input int readyPct, input int resDelay, input bit jitter,
                          input bit swapFirst, input bit startNoise, input int abortAt);
    bit aborted;
    aborted = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    running   = 1'b1;
    cmdIdx    = 0;
    inflight  = 0;
    resExpIdx = 0;
    expErr    = 1'b0;
    resBlkQ.delete();
    resDueQ.delete();
    for (int c = 0; c < FRAME_LIMIT && running && !aborted; c++) begin
      @(negedge clk);
      applyStimulus(readyPct, resDelay, jitter, swapFirst, startNoise);
      if ((abortAt > 0) && (cmdIdx >= abortAt)) aborted = 1'b1;
    end
    if (aborted) begin
      applyReset();
    end else begin
      checkOutput("frame_timeout", running, 0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        applyStimulus(readyPct, resDelay, jitter, swapFirst, 1'b0);
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    cmd_ready     = 1'b0;
    res_valid     = 1'b0;
    res_blk_index = '0;
    running       = 1'b0;
    cmdIdx        = 0;
    inflight      = 0;
    resExpIdx     = 0;
    expErr        = 1'b0;
    stallSeen     = 0;
    cycleNum      = 0;
    framesDone    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cmd_valid", cmd_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_cmd_coords", cmd_coords, 0);
    checkOutput("reset_cmd_blk_index", cmd_blk_index, 0);
    checkOutput("reset_cmd_last", cmd_last, 0);
    checkOutput("reset_err", err, 0);
    reset_n = 1'b1;

    $display("[TB] frame 1: always ready, results 20 cycles after each last beat");
    runFrame(100, 20, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("cmd_count", cmdIdx, TOTAL);
    checkOutput("frames_done_1", framesDone, 1);
    checkOutput("credit_stall_seen", stallSeen > 0, 1);

    $display("[TB] frame 2: random ready, stray start pulses");
    runFrame(50, 6, 1'b1, 1'b0, 1'b1, 0);
    checkOutput("frames_done_2", framesDone, 2);

    $display("[TB] frame 3: first two results swapped");
    runFrame(100, 3, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("err_sticky", err, 1);

    $display("[TB] frame 4: reset in the middle of block 5");
    runFrame(70, 4, 1'b1, 1'b0, 1'b0, 5 * PER_BLK + 7);
    checkOutput("frames_after_abort", framesDone, 3);

    $display("[TB] frame 5: restart after reset");
    runFrame(80, 5, 1'b1, 1'b0, 1'b1, 0);
    checkOutput("frames_total", framesDone, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/match_search_scheduler.md
# match_search_scheduler

Sequences the block-matching datapath for one frame. For every reference block it issues each candidate search offset in a fixed order, tagging the last offset of each block. It limits how many blocks may be awaiting a minimum-distance result and checks that results return in block order. It sits between the frame/stripe controller (start, frame_done) and the XOR/popcount pipeline that feeds the minimum-distance stage; it consumes that stage's result strobe.

## Interface
- blk_w, 16: block width in pixels
- blk_h, 16: block height in pixels
- search_blk_w, 64: search window width
- search_blk_h, 24: search window height
- n_blks, 300: blocks per frame, 1..65535
- max_outstanding, 2: blocks that may be in flight without a returned result, 1..15

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start; ignored unless idle
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse when all results of the frame have returned
- cmd_valid  out  1  command valid
- cmd_ready  in  1  datapath accepts a command
- cmd_coords  out  16  [15:8] vertical offset, [7:0] horizontal offset
- cmd_blk_index  out  16  block index of the command
- cmd_last  out  1  last offset of this block
- res_valid  in  1  minimum-distance result strobe, one per block
- res_blk_index  in  16  block index of the result
- err  out  1  sticky result-order error; cleared by an accepted start

## Operation
- Derived values: H_MAX = search_blk_w − blk_w; V_MAX = search_blk_h − blk_h (defaults 48 and 8). Offsets per block = (H_MAX+1)·(V_MAX+1). Both maxima must be ≤ 255; enforce with an elaboration-time assertion.
- Scan order within a block: horizontal outer, vertical inner. Sequence is (h0,v0), (h0,v1) … (h0,vV_MAX), (h1,v0) … up to (hH_MAX, vV_MAX). cmd_last = 1 only on (H_MAX, V_MAX).
- Blocks are issued in order 0 … n_blks−1.
- States:
  - IDLE: start → ISSUE. On that transition: h=v=0, blk=0, outstanding=0, exp_idx=0, err=0.
  - ISSUE: walks offsets. An accepted last beat of block n_blks−1 → DRAIN.
  - DRAIN: when outstanding == 0 → IDLE, with frame_done pulsed.
- Credit gate:
  - cmd_valid is low only on the first beat of a block when outstanding == max_outstanding. It is never low mid-block.
  - outstanding +1 on an accepted first beat; −1 on res_valid; simultaneous → unchanged.
- Result check:
  - Each res_valid compares res_blk_index with exp_idx, then increments exp_idx.
  - A mismatch sets err.
  - A res_valid while outstanding == 0 sets err and leaves outstanding at 0.
  - res_valid in IDLE is also checked and sets err.
- Counters advance only on the handshake cmd_valid && cmd_ready. v wraps to 0 and h increments; at (H_MAX, V_MAX) both wrap and blk increments.

## Timing
- Reset values: busy 0, frame_done 0, cmd_valid 0, cmd_coords 0, cmd_blk_index 0, cmd_last 0, err 0. State IDLE, all counters 0.
- Reset is asynchronous assert; its release is synchronized externally. Reset mid-frame abandons the frame silently, with no frame_done.
- All outputs are registered.
- Latency: start at cycle t → cmd_valid and busy high at t+1.
- Throughput: one command per cycle while cmd_ready = 1 and credit is available.
- While cmd_valid && !cmd_ready, cmd_coords, cmd_blk_index and cmd_last hold stable and cmd_valid stays high.
- Credit gate: a res_valid at cycle t frees credit so a stalled first beat can be valid at t+1.
- DRAIN: outstanding reaching 0 at the end of cycle t → frame_done high during t+1. busy falls in the same cycle t+1; state is IDLE at t+2.
- A start arriving in the frame_done cycle is ignored.

## Structure
- Shared package bm_pkg holds:
  - the coordinate struct: packed {v[7:0], h[7:0]}, 16 bits, matching the minimum-distance stage's coordinate port;
  - the state enum {IDLE, ISSUE, DRAIN};
  - the block-index typedef (16 bits).
- One natural sub-module: scan_counter. It holds the h/v/blk nested counters with an advance input and emits first, last and frame_last flags.

## Test plan
- Default parameters, cmd_ready = 1, results returned 20 cycles after each cmd_last, in order → 441 commands per block, 132300 total. First command (0,0) idx 0; last (48,8) idx 299 with cmd_last. frame_done once, err 0.
- max_outstanding = 2, no results until the third block's first beat → cmd_valid low at the first beat of block 2. A res_valid with index 0 → block 2 first beat valid the next cycle.
- Random cmd_ready at 50% → coords, index and last stable during stalls. Sequence is identical to the first scenario.
- Results out of order (index 1 before 0) → err set and held through frame_done. err clears on the next start.
- Assert reset_n low mid-block 5 → all outputs 0 immediately. A new start restarts at block 0, offset (0,0).
- Pulse start during ISSUE and during the frame_done cycle → no effect on the sequence or counters.
